// File: rtl/ttl_bcd_updown_counter_n_if.sv
// Control/data bundle for the multi-digit up/down modulo-N counter.
// Clock and clear stay as plain ports on the counter itself.
interface ttl_bcd_updown_counter_n_if #(
  parameter int DIGITS = 2,
  parameter int WIDTH  = 4
);
  logic                    Load_bar;
  logic                    ENT;
  logic                    ENP;
  logic                    Down;
  logic [DIGITS*WIDTH-1:0] D;
  wire  [DIGITS*WIDTH-1:0] Q;
  wire                     RCO;

  modport master (
    output Load_bar, ENT, ENP, Down, D,
    input  Q, RCO
  );

  modport slave (
    input  Load_bar, ENT, ENP, Down, D,
    output Q, RCO
  );
endinterface

// File: rtl/ttl_bcd_updown_counter_n.sv
// Cascadable DIGITS-digit up/down modulo-MODULUS counter with parallel load,
// asynchronous clear and a direction-aware terminal-count (RCO) output.
module ttl_bcd_updown_counter_n #(
  parameter int DIGITS     = 2,
  parameter int WIDTH      = 4,
  parameter int MODULUS    = 10,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                       Clk,
  input  logic                       Clear,
  ttl_bcd_updown_counter_n_if.slave  bus
);
  localparam int                NB      = DIGITS * WIDTH;
  localparam logic [WIDTH-1:0]  TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]    MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [NB-1:0] r_q_p0;
  logic [NB-1:0] w_q_nxt;
  logic          w_all_term;
  logic          w_rco;
  logic [NB:0]   w_out;

  // Out-of-range codes are never terminal, so they cannot produce a carry.
  function automatic logic is_term(input logic [WIDTH-1:0] v, input logic dn);
    return dn ? (v == '0) : (v == TOP);
  endfunction

  function automatic logic [WIDTH-1:0] step_digit(input logic [WIDTH-1:0] v,
                                                  input logic dn);
    logic in_range;
    in_range = ({1'b0, v} < MOD_EXT);
    if (!in_range || is_term(v, dn))
      return dn ? TOP : '0;
    return dn ? (v - 1'b1) : (v + 1'b1);
  endfunction

  always_comb begin : p_next
    logic c;
    c       = 1'b1;
    w_q_nxt = r_q_p0;
    for (int i = 0; i < DIGITS; i++) begin
      if (c)
        w_q_nxt[i*WIDTH +: WIDTH] = step_digit(r_q_p0[i*WIDTH +: WIDTH], bus.Down);
      c = c & is_term(r_q_p0[i*WIDTH +: WIDTH], bus.Down);
    end
    w_all_term = c;
  end

  // Stage p0: counter state; priority clear > load > count > hold.
  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear)
      r_q_p0 <= '0;
    else if (!bus.Load_bar)
      r_q_p0 <= bus.D;
    else if (bus.ENT && bus.ENP)
      r_q_p0 <= w_q_nxt;
  end

  assign w_rco = bus.ENT & ~Clear & w_all_term;
  assign w_out = {w_rco, r_q_p0};

  // Per-bit output buffers so each bit picks rise or fall delay independently.
  for (genvar b = 0; b <= NB; b++) begin : g_dly
    logic r_bit;
    always @(posedge w_out[b] or negedge w_out[b])
      r_bit <= #((w_out[b] === 1'b1) ? DELAY_RISE : DELAY_FALL) w_out[b];
    if (b < NB) begin : g_q
      assign bus.Q[b] = r_bit;
    end else begin : g_rco
      assign bus.RCO = r_bit;
    end
  end
endmodule

// File: tb/tb_ttl_bcd_updown_counter_n.sv
// Scoreboard bench for the two-digit decade up/down counter with output delays.
module tb_ttl_bcd_updown_counter_n;
  typedef struct {
    logic [7:0] q;
    logic       rco;
  } exp_t;

  logic Clk;
  logic Clear;
  exp_t sb[$];
  int   n_checks;
  int   n_pass;

  ttl_bcd_updown_counter_n_if #(.DIGITS(2), .WIDTH(4)) bus ();

  ttl_bcd_updown_counter_n #(
    .DIGITS(2), .WIDTH(4), .MODULUS(10), .DELAY_RISE(5), .DELAY_FALL(3)
  ) dut (
    .Clk   (Clk),
    .Clear (Clear),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #20 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #8;
  endtask

  task automatic push(input logic [7:0] q, input logic rco);
    exp_t e;
    e.q   = q;
    e.rco = rco;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    step();
    Clear = 1'b1;
    bus.ENT = 1'b1;
    bus.Down = 1'b1;
    #4;
    n_checks++;
    if (bus.Q !== 8'h00 || bus.RCO !== 1'b0)
      $display("FAIL reset_async: Q=%h RCO=%b, required Q=00 RCO=0", bus.Q, bus.RCO);
    else n_pass++;
    bus.Load_bar = 1'b0;
    bus.D = 8'h55;
    for (int i = 0; i < 2; i++) begin
      push(8'h00, 1'b0);
      step();
      e = sb.pop_front();
      n_checks++;
      if (bus.Q !== e.q || bus.RCO !== e.rco)
        $display("FAIL reset_hold: Q=%h RCO=%b, required Q=%h RCO=%b", bus.Q, bus.RCO, e.q, e.rco);
      else n_pass++;
    end
    Clear = 1'b0;
    push(8'h55, 1'b0);
    step();
    e = sb.pop_front();
    n_checks++;
    if (bus.Q !== e.q || bus.RCO !== e.rco)
      $display("FAIL reset_release_load: Q=%h RCO=%b, required Q=%h RCO=%b", bus.Q, bus.RCO, e.q, e.rco);
    else n_pass++;
  endtask

  task automatic test_count_up();
    exp_t e;
    bus.Load_bar = 1'b0; bus.D = 8'h98;
    bus.ENT = 1'b1; bus.ENP = 1'b1; bus.Down = 1'b0;
    push(8'h98, 1'b0);
    push(8'h99, 1'b1);
    push(8'h00, 1'b0);
    push(8'h01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      bus.Load_bar = 1'b1;
      e = sb.pop_front();
      n_checks++;
      if (bus.Q !== e.q || bus.RCO !== e.rco)
        $display("FAIL count_up[%0d]: Q=%h RCO=%b, required Q=%h RCO=%b", i, bus.Q, bus.RCO, e.q, e.rco);
      else n_pass++;
    end
  endtask

  task automatic test_count_down();
    exp_t e;
    bus.Load_bar = 1'b0; bus.D = 8'h01; bus.Down = 1'b1;
    bus.ENT = 1'b1; bus.ENP = 1'b1;
    push(8'h01, 1'b0);
    push(8'h00, 1'b1);
    push(8'h99, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      bus.Load_bar = 1'b1;
      e = sb.pop_front();
      n_checks++;
      if (bus.Q !== e.q || bus.RCO !== e.rco)
        $display("FAIL count_down[%0d]: Q=%h RCO=%b, required Q=%h RCO=%b", i, bus.Q, bus.RCO, e.q, e.rco);
      else n_pass++;
    end
    bus.Load_bar = 1'b0; bus.D = 8'h00;
    push(8'h00, 1'b1);
    step();
    bus.Load_bar = 1'b1; bus.ENP = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (bus.Q !== e.q || bus.RCO !== e.rco)
      $display("FAIL down_load00: Q=%h RCO=%b, required Q=%h RCO=%b", bus.Q, bus.RCO, e.q, e.rco);
    else n_pass++;
    bus.Down = 1'b0;
    #2;
    n_checks++;
    if (bus.RCO !== 1'b1)
      $display("FAIL dir_rco_fall_delay: RCO=%b at +2ns, required 1", bus.RCO);
    else n_pass++;
    #2;
    n_checks++;
    if (bus.Q !== 8'h00 || bus.RCO !== 1'b0)
      $display("FAIL dir_toggle: Q=%h RCO=%b, required Q=00 RCO=0", bus.Q, bus.RCO);
    else n_pass++;
  endtask

  task automatic test_hold();
    exp_t e;
    bus.Load_bar = 1'b0; bus.D = 8'h99; bus.Down = 1'b0;
    bus.ENT = 1'b1; bus.ENP = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h99, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      bus.Load_bar = 1'b1;
      e = sb.pop_front();
      n_checks++;
      if (bus.Q !== e.q || bus.RCO !== e.rco)
        $display("FAIL hold_enp[%0d]: Q=%h RCO=%b, required Q=%h RCO=%b", i, bus.Q, bus.RCO, e.q, e.rco);
      else n_pass++;
    end
    bus.ENT = 1'b0;
    #4;
    n_checks++;
    if (bus.Q !== 8'h99 || bus.RCO !== 1'b0)
      $display("FAIL hold_ent_rco: Q=%h RCO=%b, required Q=99 RCO=0", bus.Q, bus.RCO);
    else n_pass++;
    push(8'h99, 1'b0);
    push(8'h00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      bus.ENT = 1'b1; bus.ENP = 1'b1;
      e = sb.pop_front();
      n_checks++;
      if (bus.Q !== e.q || bus.RCO !== e.rco)
        $display("FAIL hold_restore[%0d]: Q=%h RCO=%b, required Q=%h RCO=%b", i, bus.Q, bus.RCO, e.q, e.rco);
      else n_pass++;
    end
  endtask

  task automatic test_invalid();
    exp_t e;
    bus.Load_bar = 1'b0; bus.D = 8'hFB; bus.Down = 1'b0;
    bus.ENT = 1'b1; bus.ENP = 1'b1;
    push(8'hFB, 1'b0);
    for (int v = 0; v < 10; v++) push({4'hF, 4'(v)}, 1'b0);
    push(8'h00, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step();
      bus.Load_bar = 1'b1;
      e = sb.pop_front();
      n_checks++;
      if (bus.Q !== e.q || bus.RCO !== e.rco)
        $display("FAIL invalid_up[%0d]: Q=%h RCO=%b, required Q=%h RCO=%b", i, bus.Q, bus.RCO, e.q, e.rco);
      else n_pass++;
    end
    bus.Load_bar = 1'b0; bus.D = 8'hFB; bus.Down = 1'b1;
    push(8'hFB, 1'b0);
    push(8'hF9, 1'b0);
    push(8'hF8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      bus.Load_bar = 1'b1;
      e = sb.pop_front();
      n_checks++;
      if (bus.Q !== e.q || bus.RCO !== e.rco)
        $display("FAIL invalid_down[%0d]: Q=%h RCO=%b, required Q=%h RCO=%b", i, bus.Q, bus.RCO, e.q, e.rco);
      else n_pass++;
    end
  endtask

  task automatic test_async_clear();
    exp_t e;
    bus.Load_bar = 1'b0; bus.D = 8'h37; bus.Down = 1'b0;
    bus.ENT = 1'b1; bus.ENP = 1'b1;
    push(8'h37, 1'b0);
    step();
    bus.Load_bar = 1'b1;
    e = sb.pop_front();
    n_checks++;
    if (bus.Q !== e.q || bus.RCO !== e.rco)
      $display("FAIL clr_load37: Q=%h RCO=%b, required Q=%h RCO=%b", bus.Q, bus.RCO, e.q, e.rco);
    else n_pass++;
    Clear = 1'b1;
    #4;
    n_checks++;
    if (bus.Q !== 8'h00 || bus.RCO !== 1'b0)
      $display("FAIL clr_midcount: Q=%h RCO=%b, required Q=00 RCO=0", bus.Q, bus.RCO);
    else n_pass++;
    #16;
    Clear = 1'b0;
    push(8'h01, 1'b0);
    step();
    e = sb.pop_front();
    n_checks++;
    if (bus.Q !== e.q || bus.RCO !== e.rco)
      $display("FAIL clr_resume: Q=%h RCO=%b, required Q=%h RCO=%b", bus.Q, bus.RCO, e.q, e.rco);
    else n_pass++;
    bus.ENP = 1'b0;
    bus.Load_bar = 1'b0; bus.D = 8'hEE;
    #4;
    n_checks++;
    if (bus.Q !== 8'h01)
      $display("FAIL load_between_edges: Q=%h, required Q=01", bus.Q);
    else n_pass++;
    #11;
    bus.Load_bar = 1'b1;
    push(8'h01, 1'b0);
    step();
    e = sb.pop_front();
    n_checks++;
    if (bus.Q !== e.q || bus.RCO !== e.rco)
      $display("FAIL load_pulse_ignored: Q=%h RCO=%b, required Q=%h RCO=%b", bus.Q, bus.RCO, e.q, e.rco);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] ld_val [4];
    logic       ld_dn  [4];
    logic       ld_en  [4];
    ld_val = '{8'h19, 8'h00, 8'h10, 8'h00};
    ld_dn  = '{1'b0, 1'b0, 1'b1, 1'b1};
    ld_en  = '{1'b1, 1'b0, 1'b1, 1'b0};
    push(8'h19, 1'b0);
    push(8'h20, 1'b0);
    push(8'h10, 1'b0);
    push(8'h09, 1'b0);
    bus.ENT = 1'b1; bus.ENP = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.Load_bar = ~ld_en[i];
      bus.D = ld_val[i];
      bus.Down = ld_dn[i];
      step();
      e = sb.pop_front();
      n_checks++;
      if (bus.Q !== e.q || bus.RCO !== e.rco)
        $display("FAIL back_to_back[%0d]: Q=%h RCO=%b, required Q=%h RCO=%b", i, bus.Q, bus.RCO, e.q, e.rco);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    Clear = 1'b0;
    bus.Load_bar = 1'b1;
    bus.ENT = 1'b0;
    bus.ENP = 1'b0;
    bus.Down = 1'b0;
    bus.D = 8'h00;
    test_reset();
    test_count_up();
    test_count_down();
    test_hold();
    test_invalid();
    test_async_clear();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ttl_bcd_updown_counter_n.md
Name: ttl_bcd_updown_counter_n

Overview:
- Cascadable multi-digit up/down modulo-N counter with parallel load and asynchronous clear.
- Generalises the single-digit decade counter in the 7400 family to DIGITS digits of configurable modulus.
- Adds a direction input with a direction-aware terminal-count (RCO) output.
- Internal digit-to-digit carry is synchronous, so no external ripple is needed; RCO allows wider chaining across instances.

Parameters:
DIGITS, 2, number of cascaded digits (>=1)
WIDTH, 4, bits per digit
MODULUS, 10, count modulus per digit; legal range 2..2**WIDTH
DELAY_RISE, 0, propagation delay on rising Q/RCO bits
DELAY_FALL, 0, propagation delay on falling Q/RCO bits

Ports:
Clk  input  1  clock, rising-edge active
Clear  input  1  asynchronous reset, active-high
Load_bar  input  1  synchronous parallel load, active-low
ENT  input  1  count enable T; also gates RCO
ENP  input  1  count enable P
Down  input  1  0 = count up, 1 = count down
D  input  DIGITS*WIDTH  parallel load data; digit 0 = least significant, bits [WIDTH-1:0]
Q  output  DIGITS*WIDTH  counter state, same digit layout as D
RCO  output  1  ripple carry/borrow out

Behaviour:
- One clock (Clk); reset is asynchronous and active-high (Clear).
- No power-on value: Q and RCO are X until the first Clear or load.
- Clear=1 sets every digit to 0 immediately, independent of Clk, and holds Q=0 while high; RCO=0 while Clear is high.
- Priority at each rising Clk edge: Clear > load > count > hold.
- Load (Load_bar=0): Q <= D at the edge, regardless of ENT/ENP/Down. Out-of-range digit values (>= MODULUS) are loaded as-is.
- Count (Load_bar=1, ENT=1, ENP=1):
  - Digit 0 steps every edge.
  - Digit i (i>0) steps only when all digits 0..i-1 are terminal for the current direction.
- Terminal value: MODULUS-1 when counting up, 0 when counting down.
- Up step: terminal -> 0; valid v -> v+1; out-of-range -> 0. An out-of-range digit is never terminal, so it produces no carry.
- Down step: 0 -> MODULUS-1; valid v -> v-1; out-of-range -> MODULUS-1, with no borrow.
- Hold: ENT=0 or ENP=0 with Load_bar=1 leaves Q unchanged.
- Control changes between edges have no effect on Q.
- RCO = ENT & ~Clear & (all digits terminal for the current Down).
  - Combinational: follows ENT and Down asynchronously.
  - Independent of ENP.
  - Goes to 0 when Q leaves terminal.
- Direction change takes effect at the next edge. RCO re-evaluates immediately against the new terminal value.
- Wrap-around: full-count terminal (up: all MODULUS-1; down: all 0) steps to all 0 / all MODULUS-1 in a single edge.
- Clear released between edges: the next edge counts or loads normally from 0. Clear released coincident with an edge: that edge is ignored.
- X on any control input propagates X to Q/RCO, per the family convention.
- Q and RCO are driven through #(DELAY_RISE, DELAY_FALL). All functional state changes use zero delay internally.
- Width arithmetic is per digit on WIDTH bits. There is no overflow beyond RCO.

Test Plan (DIGITS=2, WIDTH=4, MODULUS=10, DELAY_RISE=5, DELAY_FALL=3):
1. From X state, Clear=1 between edges -> Q still X at +2ns, Q=8'h00 and RCO=0 at +4ns. Edges while Clear=1 with Load_bar=0, D=8'h55 -> Q stays 8'h00.
2. Load D=8'h98, then ENT=ENP=1, Down=0 -> successive edges give 8'h99 (RCO=1), then 8'h00 (RCO=0), then 8'h01.
3. Load 8'h01, Down=1, ENT=ENP=1 -> next edge 8'h00 with RCO=1; following edge 8'h99 with RCO=0. At 8'h00, toggle Down=0 -> RCO falls within 3ns and Q is unchanged.
4. At 8'h99, Down=0, ENP=0 -> Q holds 8'h99 over 3 edges, RCO=1. ENT=0 -> RCO=0 within 3ns, Q holds. Restore ENT=ENP=1 -> next edge Q=8'h00.
5. Load 8'hFB (both digits invalid), count up -> first edge 8'hF0, then 8'hF1..8'hF9, then 8'h00 on the 11th edge. RCO=0 throughout except never asserted at 8'hF9.
6. Mid-count at 8'h37: pulse Clear=1 for 20ns between edges -> Q=8'h00 within 3ns. After release, next edge gives 8'h01. Load_bar=0 pulsed 15ns between edges with D=8'hEE -> no change to Q.
